// File: rtl/crono_regresivo.sv
// BCD countdown timer 59..00 with start/pause button, programmable preset and
// a prescaler that sets how many clk cycles make up one count tick.
module crono_regresivo #(
  parameter int DIV      = 1,
  parameter int PRESET_U = 9,
  parameter int PRESET_D = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ctrl,
  input  logic       load,
  input  logic [3:0] set_u,
  input  logic [3:0] set_d,
  output logic [3:0] u,
  output logic [3:0] d,
  output logic       running,
  output logic       done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TICK_AT = CW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_ctrl_q;
  logic [3:0]    r_pre_u;
  logic [3:0]    r_pre_d;
  logic [3:0]    w_pre_u_nxt;
  logic [3:0]    w_pre_d_nxt;
  logic [3:0]    r_u;
  logic [3:0]    r_d;
  logic [3:0]    w_u_nxt;
  logic [3:0]    w_d_nxt;
  logic          r_running;
  logic          r_done;
  logic          w_running_nxt;
  logic          w_done_nxt;

  logic       w_ctrl_rise;
  logic       w_tick;
  logic [3:0] w_dec_u;
  logic [3:0] w_dec_d;
  logic       w_dec_zero;

  assign w_ctrl_rise = ctrl & ~r_ctrl_q;
  assign w_tick      = (r_cnt == TICK_AT);
  assign w_dec_u     = (r_u == 4'd0) ? 4'd9 : (r_u - 4'd1);
  assign w_dec_d     = (r_u == 4'd0) ? (r_d - 4'd1) : r_d;
  assign w_dec_zero  = (w_dec_u == 4'd0) && (w_dec_d == 4'd0);

  // State register: FSM state, digits, preset, prescaler and registered status
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_ctrl_q  <= 1'b0;
      r_pre_u   <= 4'(PRESET_U);
      r_pre_d   <= 4'(PRESET_D);
      r_u       <= 4'(PRESET_U);
      r_d       <= 4'(PRESET_D);
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ctrl_q  <= ctrl;
      r_pre_u   <= w_pre_u_nxt;
      r_pre_d   <= w_pre_d_nxt;
      r_u       <= w_u_nxt;
      r_d       <= w_d_nxt;
      r_running <= w_running_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Next-state logic; priority is load, then expiry, then the ctrl edge
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pre_u_nxt = r_pre_u;
    w_pre_d_nxt = r_pre_d;
    w_u_nxt     = r_u;
    w_d_nxt     = r_d;
    if (load) begin
      w_pre_u_nxt = (set_u > 4'd9) ? 4'd9 : set_u;
      w_pre_d_nxt = (set_d > 4'd5) ? 4'd5 : set_d;
      w_u_nxt     = w_pre_u_nxt;
      w_d_nxt     = w_pre_d_nxt;
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_ctrl_rise) begin
            w_state_nxt = ({r_d, r_u} == 8'h00) ? DONE : RUN;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        RUN: begin
          if (w_tick) begin
            w_cnt_nxt = '0;
            w_u_nxt   = w_dec_u;
            w_d_nxt   = w_dec_d;
            if (w_dec_zero) begin
              w_state_nxt = DONE;
            end else if (w_ctrl_rise) begin
              w_state_nxt = PAUSE;
            end else begin
              w_state_nxt = RUN;
            end
          end else if (w_ctrl_rise) begin
            // the pause cycle itself is not counted; resume continues from here
            w_state_nxt = PAUSE;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        PAUSE: begin
          if (w_ctrl_rise) begin
            w_state_nxt = RUN;
          end else begin
            w_state_nxt = PAUSE;
          end
        end
        DONE: begin
          if (w_ctrl_rise) begin
            w_state_nxt = IDLE;
            w_u_nxt     = r_pre_u;
            w_d_nxt     = r_pre_d;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = DONE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Status decodes of the upcoming state, registered alongside it
  always_comb begin
    w_running_nxt = 1'b0;
    w_done_nxt    = 1'b0;
    case (w_state_nxt)
      RUN:     w_running_nxt = 1'b1;
      DONE:    w_done_nxt    = 1'b1;
      default: begin
        w_running_nxt = 1'b0;
        w_done_nxt    = 1'b0;
      end
    endcase
  end

  assign u       = r_u;
  assign d       = r_d;
  assign running = r_running;
  assign done    = r_done;

endmodule

// File: tb/tb_crono_regresivo.sv
// Directed bench for crono_regresivo: three instances (DIV=1,4,3) share the
// stimulus; each scenario checks the instance whose prescale it exercises.
module tb_crono_regresivo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ctrl = 1'b0;
  logic       load = 1'b0;
  logic [3:0] set_u = 4'd0;
  logic [3:0] set_d = 4'd0;

  logic [3:0] u_a, d_a, u_b, d_b, u_c, d_c;
  logic       run_a, done_a, run_b, done_b, run_c, done_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  crono_regresivo #(.DIV(1), .PRESET_U(9), .PRESET_D(5)) dut_a (
    .clk(clk), .rst(rst), .ctrl(ctrl), .load(load), .set_u(set_u), .set_d(set_d),
    .u(u_a), .d(d_a), .running(run_a), .done(done_a)
  );
  crono_regresivo #(.DIV(4), .PRESET_U(9), .PRESET_D(5)) dut_b (
    .clk(clk), .rst(rst), .ctrl(ctrl), .load(load), .set_u(set_u), .set_d(set_d),
    .u(u_b), .d(d_b), .running(run_b), .done(done_b)
  );
  crono_regresivo #(.DIV(3), .PRESET_U(9), .PRESET_D(5)) dut_c (
    .clk(clk), .rst(rst), .ctrl(ctrl), .load(load), .set_u(set_u), .set_d(set_d),
    .u(u_c), .d(d_c), .running(run_c), .done(done_c)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp_v);
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    ctrl = 1'b0;
    load = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] ld, input logic [3:0] lu);
    load  = 1'b1;
    set_d = ld;
    set_u = lu;
    step();
    load = 1'b0;
  endtask

  task automatic press();
    ctrl = 1'b1;
    step();
    ctrl = 1'b0;
  endtask

  initial begin
    // 1: DIV=1 full countdown 59 -> 00
    do_reset();
    check_val("t1_rst_du", {d_a, u_a}, 8'h59);
    check_val("t1_rst_run", {7'd0, run_a}, 8'h00);
    check_val("t1_rst_done", {7'd0, done_a}, 8'h00);
    check_val("t1_rst_du_c", {d_c, u_c}, 8'h59);
    press();
    check_val("t1_start_run", {7'd0, run_a}, 8'h01);
    check_val("t1_start_du", {d_a, u_a}, 8'h59);
    step();
    check_val("t1_k1", {d_a, u_a}, 8'h58);
    repeat (8) step();
    check_val("t1_k9", {d_a, u_a}, 8'h50);
    step();
    check_val("t1_borrow", {d_a, u_a}, 8'h49);
    repeat (48) step();
    check_val("t1_k58", {d_a, u_a}, 8'h01);
    check_val("t1_k58_run", {7'd0, run_a}, 8'h01);
    step();
    check_val("t1_end_du", {d_a, u_a}, 8'h00);
    check_val("t1_end_done", {7'd0, done_a}, 8'h01);
    check_val("t1_end_run", {7'd0, run_a}, 8'h00);
    step();
    check_val("t1_hold00", {d_a, u_a}, 8'h00);

    // 2: DIV=4 timing, held ctrl gives one pause, resume keeps prescaler
    do_reset();
    do_load(4'd1, 4'd0);
    check_val("t2_load", {d_b, u_b}, 8'h10);
    press();
    check_val("t2_start_run", {7'd0, run_b}, 8'h01);
    repeat (3) step();
    check_val("t2_k3", {d_b, u_b}, 8'h10);
    step();
    check_val("t2_k4", {d_b, u_b}, 8'h09);
    step();
    ctrl = 1'b1;
    repeat (10) step();
    check_val("t2_pause_run", {7'd0, run_b}, 8'h00);
    check_val("t2_pause_done", {7'd0, done_b}, 8'h00);
    check_val("t2_pause_du", {d_b, u_b}, 8'h09);
    ctrl = 1'b0;
    step();
    check_val("t2_still_paused", {7'd0, run_b}, 8'h00);
    press();
    check_val("t2_resume_run", {7'd0, run_b}, 8'h01);
    step();
    step();
    check_val("t2_resume_k2", {d_b, u_b}, 8'h09);
    step();
    check_val("t2_resume_tick", {d_b, u_b}, 8'h08);

    // 3: clamping and load priority over a ctrl edge while running
    do_reset();
    do_load(4'd1, 4'd1);
    check_val("t3_load11", {d_a, u_a}, 8'h11);
    do_load(4'd7, 4'd12);
    check_val("t3_clamp_both", {d_a, u_a}, 8'h59);
    check_val("t3_clamp_run", {7'd0, run_a}, 8'h00);
    do_load(4'd6, 4'd3);
    check_val("t3_clamp_d", {d_a, u_a}, 8'h53);
    do_load(4'd5, 4'd9);
    press();
    repeat (26) step();
    check_val("t3_at33", {d_a, u_a}, 8'h33);
    check_val("t3_at33_run", {7'd0, run_a}, 8'h01);
    load  = 1'b1;
    ctrl  = 1'b1;
    set_d = 4'd4;
    set_u = 4'd2;
    step();
    load = 1'b0;
    ctrl = 1'b0;
    check_val("t3_ld_prio_du", {d_a, u_a}, 8'h42);
    check_val("t3_ld_prio_run", {7'd0, run_a}, 8'h00);
    check_val("t3_ld_prio_done", {7'd0, done_a}, 8'h00);
    step();
    check_val("t3_idle_hold", {d_a, u_a}, 8'h42);

    // 4: start from 00 goes straight to DONE
    do_load(4'd0, 4'd0);
    press();
    check_val("t4_done", {7'd0, done_a}, 8'h01);
    check_val("t4_run", {7'd0, run_a}, 8'h00);
    check_val("t4_du", {d_a, u_a}, 8'h00);
    step();
    press();
    check_val("t4_ack_done", {7'd0, done_a}, 8'h00);
    check_val("t4_ack_du", {d_a, u_a}, 8'h00);

    // 5: expiry beats a ctrl edge on the final tick
    do_load(4'd0, 4'd2);
    press();
    step();
    check_val("t5_at01", {d_a, u_a}, 8'h01);
    press();
    check_val("t5_exp_done", {7'd0, done_a}, 8'h01);
    check_val("t5_exp_run", {7'd0, run_a}, 8'h00);
    check_val("t5_exp_du", {d_a, u_a}, 8'h00);
    step();
    press();
    check_val("t5_reload", {d_a, u_a}, 8'h02);
    check_val("t5_reload_done", {7'd0, done_a}, 8'h00);

    // 6: DIV=3 reset mid-prescale, then a full-length first tick
    do_reset();
    press();
    repeat (96) step();
    check_val("t6_at27", {d_c, u_c}, 8'h27);
    step();
    do_reset();
    check_val("t6_rst_du", {d_c, u_c}, 8'h59);
    check_val("t6_rst_run", {7'd0, run_c}, 8'h00);
    check_val("t6_rst_done", {7'd0, done_c}, 8'h00);
    press();
    check_val("t6_restart_run", {7'd0, run_c}, 8'h01);
    step();
    step();
    check_val("t6_k2", {d_c, u_c}, 8'h59);
    step();
    check_val("t6_k3", {d_c, u_c}, 8'h58);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
